// File: rtl/palette_arbiter.sv
// -----------------------------------------------------------------------------
// palette_arbiter
//
// Shares one combinational palette lookup among NREQ requesters. One request
// is granted per cycle; the palette colour for the granted index is captured
// into a single response register that the consumer drains with a
// valid/ready handshake. A new lookup may be accepted in the same cycle the
// held response is taken, so one lookup per cycle is sustained.
//
// Optional feature macro: PALETTE_RR_EN
//   undefined : fixed priority, lowest requester number wins
//   defined   : round-robin, search starts after the last granted requester
//
// Ports
//   Clk           clock, all state on rising edge
//   Reset         synchronous active-high reset
//   req_valid     [NREQ]       requester i has a lookup pending
//   req_index     [NREQ*IDXW]  index of requester i at [i*IDXW +: IDXW]
//   req_ready     [NREQ]       one-hot grant (combinational)
//   pal_index     [IDXW]       index presented to the shared palette
//   pal_red/green/blue [4]     palette colour for pal_index, same cycle
//   rsp_valid                  response register holds a result
//   rsp_id        [2]          requester that owns the response
//   rsp_rgb       [12]         {red, green, blue} of the response
//   rsp_ready                  consumer takes the response
//   lookup_count  [16]         number of accepted lookups, wraps
// -----------------------------------------------------------------------------
module palette_arbiter #(
    parameter int NREQ = 3,
    parameter int IDXW = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*IDXW-1:0]   req_index,
    output logic [NREQ-1:0]        req_ready,
    output logic [IDXW-1:0]        pal_index,
    input  logic [3:0]             pal_red,
    input  logic [3:0]             pal_green,
    input  logic [3:0]             pal_blue,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [11:0]            rsp_rgb,
    input  logic                   rsp_ready,
    output logic [15:0]            lookup_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            r_state;
    logic [1:0]        r_rsp_id;
    logic [11:0]       r_rsp_rgb;
    logic [IDXW-1:0]   r_pal_index;
    logic [15:0]       r_count;

    logic [2:0]        w_pick;      // {found, requester number}
    logic [1:0]        w_sel_id;
    logic              w_grant_en;
    logic              w_accept;
    logic [IDXW-1:0]   w_req_idx;

`ifdef PALETTE_RR_EN
    logic [1:0]        r_ptr;

    // Scan offsets from the far end down to ptr+1 so the nearest
    // candidate after the pointer is the last (winning) assignment.
    function automatic logic [2:0] pick_rr(input logic [NREQ-1:0] v,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        int         c;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            c = (int'(ptr) + k) % NREQ;
            if (v[c]) res = {1'b1, 2'(c)};
        end
        return res;
    endfunction

    assign w_pick = pick_rr(req_valid, r_ptr);

    always_ff @(posedge Clk) begin
        if (Reset)
            r_ptr <= 2'(NREQ - 1);
        else if (w_accept)
            r_ptr <= w_sel_id;
    end
`else
    // Descending scan: the lowest pending requester is written last and wins.
    function automatic logic [2:0] pick_fixed(input logic [NREQ-1:0] v);
        logic [2:0] res;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign w_pick = pick_fixed(req_valid);
`endif

    assign w_sel_id   = w_pick[1:0];
    // The response slot is free when empty, or when it drains this cycle.
    assign w_grant_en = (r_state == EMPTY) || rsp_ready;
    assign w_accept   = w_grant_en && w_pick[2] && !Reset;
    assign w_req_idx  = req_index[int'(w_sel_id)*IDXW +: IDXW];

    assign req_ready  = w_accept ? (NREQ'(1) << w_sel_id) : '0;
    // Index is not registered on the way out: the palette answers in the
    // grant cycle. Without a grant the previous index is held.
    assign pal_index  = w_accept ? w_req_idx : r_pal_index;

    assign rsp_valid    = (r_state == FULL);
    assign rsp_id       = r_rsp_id;
    assign rsp_rgb      = r_rsp_rgb;
    assign lookup_count = r_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= EMPTY;
            r_rsp_id    <= '0;
            r_rsp_rgb   <= '0;
            r_pal_index <= '0;
            r_count     <= '0;
        end else if (w_accept) begin
            r_state     <= FULL;
            r_rsp_id    <= w_sel_id;
            r_rsp_rgb   <= {pal_red, pal_green, pal_blue};
            r_pal_index <= w_req_idx;
            r_count     <= r_count + 16'd1;
        end else if (r_state == FULL && rsp_ready) begin
            r_state     <= EMPTY;
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
module tb_palette_arbiter;
    localparam int NREQ = 3;
    localparam int IDXW = 8;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IDXW-1:0] req_index;
    logic [NREQ-1:0]      req_ready;
    logic [IDXW-1:0]      pal_index;
    logic [3:0]           pal_red, pal_green, pal_blue;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [11:0]          rsp_rgb;
    logic                 rsp_ready;
    logic [15:0]          lookup_count;

    palette_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb),
        .rsp_ready(rsp_ready), .lookup_count(lookup_count)
    );

    always #5 Clk = ~Clk;

    // Palette contents: two fixed entries used by the directed cases,
    // the rest a simple function of the index.
    function automatic logic [11:0] pal_fn(input logic [IDXW-1:0] idx);
        if (idx == 8'h00) return 12'h542;
        if (idx == 8'h30) return 12'hFFC;
        return {idx[3:0] ^ 4'h5, idx[7:4], idx[3:0] + idx[7:4]};
    endfunction

    assign {pal_red, pal_green, pal_blue} = pal_fn(pal_index);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: what the response slot holds after each edge.
    bit              m_known = 0;
    bit              m_full;
    int              m_id;
    logic [11:0]     m_rgb;
    logic [IDXW-1:0] m_pal;
    int              m_cnt;
    int              m_ptr;
    logic [NREQ-1:0] last_ready;

    function automatic logic [IDXW-1:0] idx_of(input logic [NREQ*IDXW-1:0] v, input int i);
        return v[i*IDXW +: IDXW];
    endfunction

    // Returns winning requester number or -1.
    function automatic int choose(input logic [NREQ-1:0] v, input int ptr);
`ifdef PALETTE_RR_EN
        for (int off = 1; off <= NREQ; off++)
            if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        return -1;
`else
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
`endif
    endfunction

    task automatic step(input logic rst, input logic [NREQ-1:0] v,
                        input logic [NREQ*IDXW-1:0] idx, input logic rr);
        int              win;
        logic [NREQ-1:0] exp_ready;
        logic [IDXW-1:0] exp_pal;
        @(negedge Clk);
        Reset = rst; req_valid = v; req_index = idx; rsp_ready = rr;
        #1;
        win = choose(v, m_ptr);
        exp_ready = '0;
        if (!rst && (!m_full || rr) && win >= 0) exp_ready[win] = 1'b1;
        exp_pal = (exp_ready != 0) ? idx_of(idx, win) : m_pal;
        last_ready = req_ready;
        if (m_known) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("pal_index", 32'(pal_index), 32'(exp_pal));
        end else if (rst) begin
            chk("req_ready_rst", 32'(req_ready), 32'h0);
        end
        @(posedge Clk);
        if (rst) begin
            m_full = 0; m_id = 0; m_rgb = 0; m_pal = 0; m_cnt = 0; m_ptr = NREQ - 1;
            m_known = 1;
        end else if (exp_ready != 0) begin
            m_full = 1; m_id = win; m_pal = idx_of(idx, win);
            m_rgb = pal_fn(m_pal); m_cnt = (m_cnt + 1) % 65536; m_ptr = win;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        #1;
        if (m_known) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
            chk("lookup_count", 32'(lookup_count), 32'(m_cnt));
            if (m_full || rst) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_rgb", 32'(rsp_rgb), 32'(m_rgb));
            end
        end
    endtask

    function automatic logic [NREQ*IDXW-1:0] pack(input logic [IDXW-1:0] a,
                                                  input logic [IDXW-1:0] b,
                                                  input logic [IDXW-1:0] c);
        return {c, b, a};
    endfunction

    logic [11:0]          held_rgb;
    logic [IDXW-1:0]      cur_idx [NREQ];
    logic [NREQ-1:0]      cur_v;
    logic [NREQ*IDXW-1:0] cur_pack;

    initial begin
        Reset = 1'b0; req_valid = '0; req_index = '0; rsp_ready = 1'b0;

        // Reset with all requesters pending: no grant may appear
        step(1, 3'b111, pack(8'h11, 8'h22, 8'h33), 1);
        step(1, 3'b111, pack(8'h11, 8'h22, 8'h33), 1);
        chk("rst_ready", 32'(last_ready), 32'h0);
        chk("rst_pal_index", 32'(pal_index), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);

        // Single lookup, one-cycle latency
        step(0, 3'b001, pack(8'h30, 8'h00, 8'h00), 1);
        chk("first_rgb", 32'(rsp_rgb), 32'hFFC);
        chk("first_id", 32'(rsp_id), 32'h0);
        chk("first_valid", 32'(rsp_valid), 32'h1);
        chk("first_count", 32'(lookup_count), 32'h1);

        // All requesters pending for three cycles from a fresh pointer
        step(1, 3'b000, '0, 1);
        step(0, 3'b111, pack(8'h01, 8'h02, 8'h03), 1);
`ifdef PALETTE_RR_EN
        chk("sel_c0", 32'(last_ready), 32'h1);
        step(0, 3'b111, pack(8'h01, 8'h02, 8'h03), 1);
        chk("sel_c1", 32'(last_ready), 32'h2);
        step(0, 3'b111, pack(8'h01, 8'h02, 8'h03), 1);
        chk("sel_c2", 32'(last_ready), 32'h4);
`else
        chk("sel_c0", 32'(last_ready), 32'h1);
        step(0, 3'b111, pack(8'h01, 8'h02, 8'h03), 1);
        chk("sel_c1", 32'(last_ready), 32'h1);
        step(0, 3'b111, pack(8'h01, 8'h02, 8'h03), 1);
        chk("sel_c2", 32'(last_ready), 32'h1);
`endif

        // Stall: response held while consumer is not ready
        step(0, 3'b001, pack(8'h45, 8'h67, 8'h00), 1);
        held_rgb = rsp_rgb;
        chk("stall_full", 32'(rsp_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'b010, pack(8'h45, 8'h67, 8'h00), 0);
            chk("stall_ready", 32'(last_ready), 32'h0);
            chk("stall_rgb", 32'(rsp_rgb), 32'(held_rgb));
        end
        step(0, 3'b010, pack(8'h45, 8'h67, 8'h00), 1);
        chk("stall_release", 32'(last_ready), 32'h2);
        chk("stall_new_id", 32'(rsp_id), 32'h1);

        // Back-to-back lookups from requester 2
        step(0, 3'b100, pack(8'h00, 8'h00, 8'h00), 1);
        chk("b2b_rgb0", 32'(rsp_rgb), 32'h542);
        chk("b2b_id0", 32'(rsp_id), 32'h2);
        step(0, 3'b100, pack(8'h00, 8'h00, 8'h30), 1);
        chk("b2b_rgb1", 32'(rsp_rgb), 32'hFFC);
        chk("b2b_id1", 32'(rsp_id), 32'h2);
        chk("b2b_valid1", 32'(rsp_valid), 32'h1);

        // Reset while holding a response
        step(0, 3'b001, pack(8'h12, 8'h00, 8'h00), 0);
        step(1, 3'b001, pack(8'h12, 8'h00, 8'h00), 0);
        chk("rstfull_valid", 32'(rsp_valid), 32'h0);
        chk("rstfull_count", 32'(lookup_count), 32'h0);
        step(0, 3'b000, '0, 1);
        chk("rstfull_after", 32'(rsp_valid), 32'h0);

        // Random traffic; a requester keeps its index until granted
        for (int i = 0; i < NREQ; i++) cur_idx[i] = 8'($urandom);
        cur_v = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!cur_v[i]) begin
                    cur_v[i] = ($urandom_range(0, 2) != 0);
                    cur_idx[i] = ($urandom_range(0, 7) == 0) ? 8'h30 : 8'($urandom);
                end
            end
            cur_pack = pack(cur_idx[0], cur_idx[1], cur_idx[2]);
            step(($urandom_range(0, 99) == 0), cur_v, cur_pack, ($urandom_range(0, 3) != 0));
            for (int i = 0; i < NREQ; i++)
                if (last_ready[i] || Reset) cur_v[i] = 1'b0;
        end

        // Counter wrap after 65536 accepts
        step(1, 3'b000, '0, 1);
        for (int n = 0; n < 65535; n++)
            step(0, 3'b001, pack(8'(n), 8'h00, 8'h00), 1);
        chk("wrap_pre", 32'(lookup_count), 32'hFFFF);
        step(0, 3'b001, pack(8'h30, 8'h00, 8'h00), 1);
        chk("wrap_zero", 32'(lookup_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
